// File: rtl/mem_spi_dumper.sv
// mem_spi_dumper: streams a block of result words out of data memory into an
// SPI master, one byte at a time, MSB first within each word.
//
// Ports:
//   clk       system clock, all state updates on posedge
//   rst       synchronous active-low reset
//   start     level, sampled only in IDLE, kicks off the dump
//   mem_addr  byte address to data memory, BASE_ADDR + 4*idx
//   mem_rd    combinational read data for mem_addr
//   spi_wd    registered byte presented to the SPI master
//   spi_send  one-cycle transmit request (valid in SEND while master idle)
//   spi_busy  SPI master busy
//   spi_rdy   one-cycle pulse, byte transfer complete
//   busy      high from leaving IDLE until reaching DONE
//   done      high in DONE, held until reset
module mem_spi_dumper #(
  parameter int unsigned BASE_ADDR = 1728,
  parameter int unsigned N_WORDS   = 127,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd,
  output logic [7:0]  spi_wd,
  output logic        spi_send,
  input  logic        spi_busy,
  input  logic        spi_rdy,
  output logic        busy,
  output logic        done
);

  // Encoding is observed from outside; keep the values fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = (N_WORDS > 0) ? CNT_W'(N_WORDS - 1) : '0;

  state_e           cs;
  logic [CNT_W-1:0] idx;
  logic [1:0]       byte_cnt;
  logic [31:0]      shreg_q;
  logic [7:0]       spi_wd_q;
  logic             busy_q;
  logic             done_q;

  assign mem_addr = 32'(BASE_ADDR) + (32'(idx) << 2);

  // The request must go out in the very cycle the master frees up, so it is
  // decoded from the state and spi_busy rather than registered.
  assign spi_send = (cs == SEND) && !spi_busy;
  assign spi_wd   = spi_wd_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // spi_wd_q is loaded with the next outgoing byte on entry to SEND, so it is
  // already stable when spi_send rises, and it holds after the final byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs       <= IDLE;
      idx      <= '0;
      byte_cnt <= '0;
      shreg_q  <= '0;
      spi_wd_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (cs)
        IDLE: begin
          if (start) begin
            if (N_WORDS > 0) begin
              cs     <= FETCH;
              busy_q <= 1'b1;
            end else begin
              cs     <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          shreg_q  <= mem_rd;
          spi_wd_q <= mem_rd[31:24];
          byte_cnt <= '0;
          cs       <= SEND;
        end
        SEND: begin
          if (!spi_busy) cs <= WAIT;
        end
        WAIT: begin
          if (spi_rdy) begin
            shreg_q <= {shreg_q[23:0], 8'h00};
            if (byte_cnt != 2'd3) begin
              byte_cnt <= byte_cnt + 2'd1;
              spi_wd_q <= shreg_q[23:16];
              cs       <= SEND;
            end else if (idx == LAST_IDX) begin
              cs     <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              cs  <= FETCH;
            end
          end
        end
        DONE: begin
          cs <= DONE;
        end
        default: begin
          cs <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_spi_dumper.sv
// Bench for mem_spi_dumper: three instances (127 words, 1 word, 0 words)
// share a data memory; each SPI master is a small behavioural model that
// records every transmitted byte. Expected bytes come straight from memory.
module tb_mem_spi_dumper;
  localparam int BASE = 1728;
  localparam int NW   = 127;
  localparam int W0   = BASE / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  // main instance
  logic [31:0] addr0;
  logic [7:0]  wd0;
  logic        send0, sbusy0, srdy0, busy0, done0;
  logic        force_busy = 1'b0, spur_rdy = 1'b0;
  // single-word instance
  logic [31:0] addr1;
  logic [7:0]  wd1;
  logic        send1, sbusy1, srdy1, busy1, done1;
  // zero-word instance
  logic [31:0] addrz;
  logic [7:0]  wdz;
  logic        sendz, busyz, donez;
  logic        zlo = 1'b0;

  mem_spi_dumper u_dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(addr0), .mem_rd(mem[addr0[11:2]]),
    .spi_wd(wd0), .spi_send(send0), .spi_busy(sbusy0), .spi_rdy(srdy0),
    .busy(busy0), .done(done0));

  mem_spi_dumper #(.N_WORDS(1)) u_one (
    .clk(clk), .rst(rst), .start(start), .mem_addr(addr1), .mem_rd(mem[addr1[11:2]]),
    .spi_wd(wd1), .spi_send(send1), .spi_busy(sbusy1), .spi_rdy(srdy1),
    .busy(busy1), .done(done1));

  mem_spi_dumper #(.N_WORDS(0)) u_zero (
    .clk(clk), .rst(rst), .start(start), .mem_addr(addrz), .mem_rd(mem[addrz[11:2]]),
    .spi_wd(wdz), .spi_send(sendz), .spi_busy(zlo), .spi_rdy(zlo),
    .busy(busyz), .done(donez));

  // SPI master models: capture byte on send, stay busy a while, pulse rdy.
  logic m0_busy = 1'b0, m0_rdy = 1'b0;
  int   m0_cnt = 0, sends0 = 0;
  logic [7:0] cap0 [$];
  assign sbusy0 = m0_busy | force_busy;
  assign srdy0  = m0_rdy | spur_rdy;
  always @(posedge clk) begin
    m0_rdy <= 1'b0;
    if (send0) begin
      cap0.push_back(wd0);
      sends0++;
      m0_busy <= 1'b1;
      m0_cnt  <= $urandom_range(1, 6);
    end else if (m0_busy) begin
      if (m0_cnt == 0) begin m0_busy <= 1'b0; m0_rdy <= 1'b1; end
      else m0_cnt <= m0_cnt - 1;
    end
  end

  logic m1_busy = 1'b0, m1_rdy = 1'b0;
  int   m1_cnt = 0, sends1 = 0, sendsz = 0;
  logic [7:0] cap1 [$];
  assign sbusy1 = m1_busy;
  assign srdy1  = m1_rdy;
  always @(posedge clk) begin
    m1_rdy <= 1'b0;
    if (send1) begin
      cap1.push_back(wd1);
      sends1++;
      m1_busy <= 1'b1;
      m1_cnt  <= 9;
    end else if (m1_busy) begin
      if (m1_cnt == 0) begin m1_busy <= 1'b0; m1_rdy <= 1'b1; end
      else m1_cnt <= m1_cnt - 1;
    end
    if (sendz) sendzz_inc();
  end

  task automatic sendzz_inc();
    sendsz++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte n of the dump: word n/4, MSB first within the word.
  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    w = mem[W0 + n / 4];
    return w[8 * (3 - n % 4) +: 8];
  endfunction

  initial begin
    int n, s0, bad, s1base;
    logic [31:0] res;
    rst = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[W0]      = 32'habcdef12;
    mem[W0 + 11] = 32'hxxxxef12;

    // reset held with start high
    repeat (3) @(negedge clk);
    chk("rst_cs", 64'(u_dut.cs), 0);
    chk("rst_send", send0, 0);
    chk("rst_done", done0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_addr", addr0, 1728);
    chk("rst_wd", wd0, 0);

    // release: FETCH next cycle, first send the cycle after
    rst = 1'b1;
    @(negedge clk);
    chk("start_cs", 64'(u_dut.cs), 1);
    chk("start_busy", busy0, 1);
    chk("zero_cs", 64'(u_zero.cs), 4);
    chk("zero_done", donez, 1);
    chk("zero_busy", busyz, 0);
    @(negedge clk);
    chk("first_send", send0, 1);
    chk("first_wd", wd0, 8'hab);
    chk("one_first_send", send1, 1);

    // run until the 2nd byte of word 5 has gone out, then reset
    n = 0;
    while (sends0 < 22 && n < 3000) begin @(negedge clk); n++; end
    chk("to_b22", 64'(n < 3000), 1);
    chk("b22_count", sends0, 22);
    chk("b22_idx", 64'(u_dut.idx), 5);
    chk("b22_bcnt", 64'(u_dut.byte_cnt), 1);
    for (int i = 0; i < 22 && i < cap0.size(); i++)
      chk($sformatf("pre_byte%0d", i), cap0[i], exp_byte(i));
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mrst_cs", 64'(u_dut.cs), 0);
    chk("mrst_idx", 64'(u_dut.idx), 0);
    chk("mrst_addr", addr0, 1728);
    chk("mrst_send", send0, 0);
    chk("mrst_busy", busy0, 0);
    repeat (15) @(negedge clk);
    chk("mrst_nosend", sends0, 22);
    chk("mrst_idle", 64'(u_dut.cs), 0);

    // restart from word 0
    cap0.delete();
    cap1.delete();
    s1base = sends1;
    start = 1'b1;
    @(negedge clk);
    chk("re_cs", 64'(u_dut.cs), 1);
    chk("re_addr", addr0, 1728);

    // spurious rdy during FETCH of word 2
    n = 0;
    while (!(u_dut.cs == 1 && u_dut.idx == 2) && n < 3000) begin @(negedge clk); n++; end
    chk("to_fetch2", 64'(n < 3000), 1);
    spur_rdy = 1'b1;
    @(negedge clk);
    spur_rdy = 1'b0;
    chk("spf_cs", 64'(u_dut.cs), 2);
    chk("spf_idx", 64'(u_dut.idx), 2);
    chk("spf_bcnt", 64'(u_dut.byte_cnt), 0);

    // backpressure on byte 1 of word 3; start toggled during WAIT
    n = 0;
    while (!(u_dut.cs == 3 && u_dut.idx == 3 && u_dut.byte_cnt == 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("to_wait3", 64'(n < 3000), 1);
    force_busy = 1'b1;
    start = 1'b0;
    n = 0;
    while (u_dut.cs != 2 && n < 100) begin @(negedge clk); n++; end
    chk("to_send3", 64'(n < 100), 1);
    chk("bp_bcnt0", 64'(u_dut.byte_cnt), 1);
    s0 = sends0;
    bad = 0;
    spur_rdy = 1'b1;
    repeat (20) begin
      @(negedge clk);
      spur_rdy = 1'b0;
      if (send0) bad++;
    end
    chk("bp_nosend", bad, 0);
    chk("bp_count", sends0, s0);
    chk("bp_cs", 64'(u_dut.cs), 2);
    chk("bp_bcnt", 64'(u_dut.byte_cnt), 1);
    force_busy = 1'b0;
    start = 1'b1;
    #1;
    chk("bp_release_send", send0, 1);
    chk("bp_release_wd", wd0, exp_byte(13));

    // run to completion
    n = 0;
    while (!done0 && n < 20000) begin @(negedge clk); n++; end
    chk("to_done", 64'(n < 20000), 1);
    chk("end_cs", 64'(u_dut.cs), 4);
    chk("end_busy", busy0, 0);
    chk("end_bytes", cap0.size(), 4 * NW);
    if (cap0.size() == 4 * NW)
      for (int w = 0; w < NW; w++) begin
        res = {cap0[4*w], cap0[4*w+1], cap0[4*w+2], cap0[4*w+3]};
        chk($sformatf("word%0d", w), res, mem[W0 + w]);
      end

    // start toggled in DONE: nothing moves
    s0 = sends0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    repeat (5) @(negedge clk);
    chk("done_cs", 64'(u_dut.cs), 4);
    chk("done_flag", done0, 1);
    chk("done_nosend", sends0, s0);
    chk("done_wd_hold", wd0, exp_byte(4 * NW - 1));

    // single-word instance (restarted along with the main one)
    chk("one_count", sends1 - s1base, 4);
    chk("one_bytes", cap1.size(), 4);
    if (cap1.size() == 4) begin
      res = {cap1[0], cap1[1], cap1[2], cap1[3]};
      chk("one_word", res, 32'habcdef12);
    end
    chk("one_cs", 64'(u_one.cs), 4);
    chk("one_done", done1, 1);
    chk("zero_nosend", sendsz, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
